// File: rtl/digit_serial_addsub.sv
// digit_serial_addsub: multi-cycle WIDTH-bit adder/subtractor that adds DIGIT
// bits per clock through one DIGIT-wide ripple stage. The carry is held in a
// register between digits, and a start/busy/done handshake frames each operation.
// Optional build macro: ADDSUB_SAT_EN clamps s to the signed limit on overflow.
module digit_serial_addsub #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             ovf
);

    localparam int NDIG  = WIDTH / DIGIT;
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NDIG - 1);

    generate
        if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_param
            $error("digit_serial_addsub: WIDTH must be a non-zero multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] bx_r;    // b, already inverted for subtraction
    logic             carry;   // carry (or inverted borrow) between digits
    logic [CNT_W-1:0] idx;

    int               lo;
    logic [DIGIT:0]   dsum;
    logic [WIDTH-1:0] s_next;
    logic             ovf_next;

`ifdef ADDSUB_SAT_EN
    // Clamp to the signed limit that matches the sign of operand A.
    function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] raw,
                                                   input logic             of,
                                                   input logic             neg);
        logic [WIDTH-1:0] lim;
        lim = {neg, {(WIDTH-1){~neg}}};
        return of ? lim : raw;
    endfunction
`endif

    // One ripple stage over the current digit; s_next merges it into the result.
    always_comb begin
        lo       = int'(idx) * DIGIT;
        dsum     = {1'b0, a_r[lo +: DIGIT]} + {1'b0, bx_r[lo +: DIGIT]}
                 + {{DIGIT{1'b0}}, carry};
        s_next   = s;
        s_next[lo +: DIGIT] = dsum[DIGIT-1:0];
        // Only meaningful on the last digit, where s_next holds the raw MSB.
        ovf_next = (a_r[WIDTH-1] == bx_r[WIDTH-1]) && (s_next[WIDTH-1] != a_r[WIDTH-1]);
    end

    // Control FSM with operand capture, digit sequencing and registered results.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            s     <= '0;
            c_out <= 1'b0;
            ovf   <= 1'b0;
            a_r   <= '0;
            bx_r  <= '0;
            carry <= 1'b0;
            idx   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r   <= a;
                        bx_r  <= sub ? ~b : b;
                        carry <= sub ? ~c_in : c_in;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    carry <= dsum[DIGIT];
                    s     <= s_next;
                    if (idx == LAST) begin
                        // Index parks at zero so it never points past the operand.
                        idx   <= '0;
                        c_out <= dsum[DIGIT];
                        ovf   <= ovf_next;
`ifdef ADDSUB_SAT_EN
                        s     <= saturate(s_next, ovf_next, a_r[WIDTH-1]);
`endif
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx <= idx + CNT_W'(1);
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
